// File: rtl/nibble_add_scheduler.sv
// ---------------------------------------------------------------------------
// nibble_add_scheduler
//
// Purpose:
//   Lets two requesters share a single 4-bit ripple-carry adder slice. Each
//   accepted request is a WIDTH-bit addition A + B + cin that is carried out
//   one nibble per cycle, least significant nibble first, with the
//   inter-nibble carry held in a register. Round-robin arbitration decides
//   which requester is served. The result is held on the response port until
//   the consumer takes it.
//
//   Timing of one operation (NIB = WIDTH/4):
//     edge T        : request handshake, operands latched, state -> ADD
//     edges T+1..T+NIB : one nibble per edge; resp_valid rises at edge T+NIB
//     DONE          : result held until resp_ready
//     IDLE          : one arbitration cycle before the next handshake
//
// Parameters:
//   WIDTH  operand/sum width in bits; must be a multiple of 4 and >= 4.
//
// Ports:
//   clk         clock; every state update happens on the rising edge
//   rst_n       synchronous active-low reset
//   req0_valid  requester 0 has an operation pending
//   req0_ready  requester 0 operation accepted this cycle
//   req0_a/b    requester 0 operands (WIDTH bits)
//   req0_cin    requester 0 carry-in
//   req1_*      same set of signals for requester 1
//   resp_valid  result available
//   resp_ready  consumer takes the result
//   resp_sum    (A + B + cin) mod 2^WIDTH
//   resp_cout   carry out of the MSB
//   resp_id     requester that issued the result
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// full_adder
//   Single-bit full adder: sum_o = a_i ^ b_i ^ c_i, carry_o = majority.
// Ports: a_i, b_i, c_i inputs; sum_o, carry_o outputs.
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// ---------------------------------------------------------------------------
// four_bit_full_adder
//   The shared 4-bit ripple-carry slice: four full adders chained LSB to MSB.
// Ports: a_i[3:0], b_i[3:0], cin_i inputs; sum_o[3:0], cout_o outputs.
// ---------------------------------------------------------------------------
module four_bit_full_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  // carry[0] is the slice carry-in, carry[4] the slice carry-out.
  logic [4:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .c_i    (carry[i]),
      .sum_o  (sum_o[i]),
      .carry_o(carry[i+1])
    );
  end

  assign cout_o = carry[4];

endmodule

// ---------------------------------------------------------------------------
// nibble_add_scheduler (top)
// ---------------------------------------------------------------------------
module nibble_add_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             resp_id
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int NIB   = WIDTH / 4;
  // Keep the counter at least one bit wide so WIDTH=4 still elaborates.
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_add_scheduler: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;         // index of the nibble being added
  logic             carry_q;       // carry into the current nibble
  logic             last_grant_q;  // requester served most recently
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;          // requester of the operation in flight

  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_sum_q;
  logic             resp_cout_q;
  logic             resp_id_q;

  // -------------------------------------------------------------------------
  // Arbitration (combinational, only meaningful in IDLE)
  // -------------------------------------------------------------------------
  logic grant_valid;
  logic grant_id;

  // NOTE: every signal written in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        // Tie: serve whoever was not served last time.
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && (grant_id == 1'b0);
  assign req1_ready = grant_valid && (grant_id == 1'b1);

  // -------------------------------------------------------------------------
  // Shared adder slice and nibble steering
  // -------------------------------------------------------------------------
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] resp_sum_d;

  // Select operand nibble k = cnt_q with constant part-selects so every
  // index stays in range for any legal WIDTH.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < NIB; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        slice_a = a_q[4*k +: 4];
        slice_b = b_q[4*k +: 4];
      end
    end
  end

  four_bit_full_adder u_slice (
    .a_i   (slice_a),
    .b_i   (slice_b),
    .cin_i (carry_q),
    .sum_o (slice_sum),
    .cout_o(slice_cout)
  );

  // Merge the slice result into nibble k of the accumulating sum; the other
  // nibbles keep what earlier cycles wrote.
  always_comb begin
    resp_sum_d = resp_sum_q;
    for (int k = 0; k < NIB; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        resp_sum_d[4*k +: 4] = slice_sum;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Operand capture
  // -------------------------------------------------------------------------
  // NOTE: the operand and id registers are deliberately left out of reset;
  // they are always written at the handshake before anything reads them.
  always_ff @(posedge clk) begin
    if (grant_valid) begin
      a_q  <= grant_id ? req1_a : req0_a;
      b_q  <= grant_id ? req1_b : req0_b;
      id_q <= grant_id;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered response outputs
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;       // requester 0 wins the first tie
      resp_valid_q <= 1'b0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            carry_q      <= grant_id ? req1_cin : req0_cin;
            cnt_q        <= '0;
            last_grant_q <= grant_id;
            state_q      <= S_ADD;
          end
        end

        S_ADD: begin
          resp_sum_q <= resp_sum_d;
          carry_q    <= slice_cout;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == LAST_NIB) begin
            resp_cout_q  <= slice_cout;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end

        S_DONE: begin
          // Response data is left untouched; it only matters while valid.
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign resp_cout  = resp_cout_q;
  assign resp_id    = resp_id_q;

  // -------------------------------------------------------------------------
  // Protocol properties
  // -------------------------------------------------------------------------
  a_ready_exclusive: assert property (@(posedge clk)
    !(req0_ready && req1_ready));

  a_ready_needs_valid: assert property (@(posedge clk)
    (!req0_ready || req0_valid) && (!req1_ready || req1_valid));

  a_resp_held: assert property (@(posedge clk) disable iff (!rst_n)
    (resp_valid && !resp_ready) |=>
      (resp_valid && $stable(resp_sum) && $stable(resp_cout) && $stable(resp_id)));

endmodule

// File: doc/nibble_add_scheduler.md
Name: nibble_add_scheduler

Overview:
- Shares one 4-bit ripple adder slice (FourBitFullAdder) between two requesters.
- Each request is a WIDTH-bit addition, executed nibble-serially over WIDTH/4 cycles with a registered carry.
- Uses round-robin arbitration, a valid/ready request handshake and a held response.
- Sits between operand producers and the shared adder; replaces wide parallel adders where area matters.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be a multiple of 4 and at least 4. NIB = WIDTH/4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_cin  input  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes result
- resp_sum  output  WIDTH  A+B+cin, low WIDTH bits
- resp_cout  output  1  carry out of the MSB
- resp_id  output  1  requester that issued the result (0/1)

Behaviour:
- Reset: synchronous; rst_n=0 sampled at a rising edge forces the following (overrides every other event, including mid-ADD and pending DONE):
  - state=IDLE
  - resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0
  - nibble counter=0, carry register=0
  - last_grant=1, so requester 0 wins the first tie
  - In-flight operation discarded; no response produced for it.
- States: IDLE, ADD, DONE.
- IDLE:
  - Grant is combinational. If only one valid is high, grant that requester. If both are high, grant the requester != last_grant. If neither, no grant.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high per cycle; ready is 0 in ADD and DONE.
  - On a handshake (valid && ready) at an edge:
    - latch A, B, id; carry register <= cin; counter <= 0
    - last_grant <= id; state -> ADD
  - Requesters must hold valid/operands stable until ready; ready never depends on resp_ready.
- ADD:
  - Each cycle drives the shared slice with A[4k+3:4k], B[4k+3:4k] and the carry register, where k = counter.
  - At the edge: the slice sum goes into resp_sum[4k+3:4k] and the slice carry-out into the carry register; counter increments.
  - When k==NIB-1: resp_cout <= slice carry-out, resp_id <= latched id, resp_valid <= 1, state -> DONE.
  - Duration is exactly NIB cycles.
- DONE:
  - resp_valid=1; resp_sum/resp_cout/resp_id held stable while resp_ready=0.
  - On resp_valid && resp_ready at an edge: resp_valid <= 0, state -> IDLE. Output data keeps its last value (don't-care when resp_valid=0).
  - No new request is accepted in the DONE cycle.
- Latency: handshake edge T → resp_valid high after edge T+NIB.
  - Best-case issue interval is NIB+2 cycles (ADD × NIB, DONE × 1, IDLE × 1).
- Arithmetic: result equals (A+B+cin) mod 2^WIDTH; cout is bit WIDTH of the full sum. Wrap-around is not an error.
- Fairness: under continuous contention, grants alternate 0,1,0,1…; no requester waits for more than one foreign operation.
- A requester that drops valid before ready is simply not granted; no state is kept for it.

Test Plan:
- WIDTH=8, req0 only: a=0x3C, b=0x5A, cin=0 → req0_ready 1 cycle; resp_valid exactly 2 cycles after the handshake edge; sum=0x96, cout=0, id=0.
- WIDTH=8, req1: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, id=1. Then a=0x0F, b=0x00, cin=1 → sum=0x10, cout=0, confirming carry propagation across the nibble boundary.
- Both valid continuously, 4 ops each (req0 a=i, b=1; req1 a=0x80+i, b=0x80) → grant order 0,1,0,1,…; each resp_id matches; req1 sums wrap correctly, e.g. 0x80+0x80 → sum=0x00, cout=1.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE → resp_valid, sum and id stable. Both reqN_ready stay 0 with req valid high. Release → resp_valid drops next cycle; next grant follows one cycle later.
- Reset mid-operation: rst_n=0 for 1 cycle during the second ADD cycle → next cycle state IDLE, resp_valid=0, outputs 0. No response for the aborted op; a subsequent tie is granted to req0.
- WIDTH=16: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, resp_valid 4 cycles after handshake.
